// File: rtl/board_line_clear_if.sv
// Bus bundle between the line-clear sequencer and its board RAM / scoring client.
// start is a one-cycle request taken only while busy=0; mem_rdata answers mem_rd_en one cycle later.
interface board_line_clear_if #(
   parameter int AW = 8,
   parameter int CW = 3
);
   logic          start;
   logic          busy;
   logic          done;
   logic [4:0]    lines_cleared;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [CW-1:0] mem_rdata;
   logic          mem_we;
   logic [CW-1:0] mem_wdata;

   modport master (
      input  start, mem_rdata,
      output busy, done, lines_cleared, mem_addr, mem_rd_en, mem_we, mem_wdata
   );

   modport slave (
      output start, mem_rdata,
      input  busy, done, lines_cleared, mem_addr, mem_rd_en, mem_we, mem_wdata
   );
endinterface

// File: rtl/board_line_clear_ctrl.sv
// Line-clear sequencer: scans rows bottom-up, drops full rows, compacts survivors
// downward and zero-fills the vacated top rows, then reports the cleared count.
module board_line_clear_ctrl #(
   parameter int COLS = 10,
   parameter int ROWS = 20,
   parameter int CW   = 3,
   parameter int AW   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   board_line_clear_if.master    bus,
   output logic [2:0]            dbg_state
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] READ  = 3'd1;
   localparam logic [2:0] EVAL  = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] FILL  = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [4:0]    src_q, src_d;
   logic [4:0]    dst_q, dst_d;
   logic          dst_valid_q, dst_valid_d;
   logic [3:0]    col_q, col_d;
   logic [4:0]    lines_q, lines_d;
   logic          rd_pend_q;
   logic [CW-1:0] rowbuf_q [COLS];
   logic [CW-1:0] rowbuf_d [COLS];

   logic          rd_en, we, full, adv;
   logic [4:0]    row_sel;
   logic [CW-1:0] wdata;

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      dst_valid_d = dst_valid_q;
      col_d       = col_q;
      lines_d     = lines_q;
      rowbuf_d    = rowbuf_q;
      rd_en       = 1'b0;
      we          = 1'b0;
      row_sel     = dst_q;
      wdata       = '0;
      adv         = 1'b0;

      // Read data lands one cycle behind its strobe, after col has advanced.
      if (rd_pend_q) rowbuf_d[col_q - 4'd1] = bus.mem_rdata;
      full = 1'b1;
      for (int i = 0; i < COLS; i++) begin
         if (rowbuf_d[i] == '0) full = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               lines_d     = '0;
               src_d       = 5'(ROWS - 1);
               dst_d       = 5'(ROWS - 1);
               dst_valid_d = 1'b1;
               col_d       = '0;
               state_d     = READ;
            end
         end
         READ: begin
            rd_en   = 1'b1;
            row_sel = src_q;
            col_d   = col_q + 4'd1;
            if (col_q == 4'(COLS - 1)) state_d = EVAL;
         end
         EVAL: begin
            if (full) begin
               if (lines_q != 5'(ROWS)) lines_d = lines_q + 5'd1;
               adv = 1'b1;
            end else if (src_q != dst_q) begin
               col_d   = '0;
               state_d = WRITE;
            end else begin
               dst_d       = dst_q - 5'd1;
               dst_valid_d = (dst_q != 5'd0);
               adv         = 1'b1;
            end
         end
         WRITE: begin
            we    = 1'b1;
            wdata = rowbuf_q[col_q];
            col_d = col_q + 4'd1;
            if (col_q == 4'(COLS - 1)) begin
               dst_d       = dst_q - 5'd1;
               dst_valid_d = (dst_q != 5'd0);
               adv         = 1'b1;
            end
         end
         FILL: begin
            we    = 1'b1;
            col_d = col_q + 4'd1;
            if (col_q == 4'(COLS - 1)) begin
               col_d = '0;
               if (dst_q == 5'd0) state_d = DONE;
               else dst_d = dst_q - 5'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A finished row either moves on to the next source row or ends the scan.
      if (adv) begin
         col_d = '0;
         if (src_q == 5'd0) begin
            state_d = dst_valid_d ? FILL : DONE;
         end else begin
            src_d   = src_q - 5'd1;
            state_d = READ;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         src_q       <= 5'(ROWS - 1);
         dst_q       <= 5'(ROWS - 1);
         dst_valid_q <= 1'b1;
         col_q       <= '0;
         lines_q     <= '0;
         rd_pend_q   <= 1'b0;
         for (int i = 0; i < COLS; i++) rowbuf_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         dst_valid_q <= dst_valid_d;
         col_q       <= col_d;
         lines_q     <= lines_d;
         rd_pend_q   <= rd_en;
         rowbuf_q    <= rowbuf_d;
      end
   end

   assign bus.busy          = (state_q != IDLE);
   assign bus.done          = (state_q == DONE);
   assign bus.lines_cleared = lines_q;
   assign bus.mem_rd_en     = rd_en;
   assign bus.mem_we        = we;
   assign bus.mem_wdata     = wdata;
   assign bus.mem_addr      = (rd_en || we) ? (AW'(row_sel) * AW'(COLS) + AW'(col_q)) : '0;
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_board_line_clear_ctrl.sv
// Bench for board_line_clear_ctrl: RAM model plus a row-list reference model of the
// clear pass, directed boards from the test plan followed by random boards.
module tb_board_line_clear_ctrl;
   localparam int COLS = 10;
   localparam int ROWS = 20;
   localparam int CW   = 3;
   localparam int AW   = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] dbg_state;
   logic       load_req;
   int         n_checks = 0;
   int         n_fail   = 0;
   int         wr_cnt   = 0;
   int         both_cnt = 0;

   logic [CW-1:0] img [ROWS][COLS];
   logic [CW-1:0] ram [ROWS*COLS];

   board_line_clear_if #(.AW(AW), .CW(CW)) bus ();

   board_line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Board RAM: synchronous write, one-cycle read latency.
   always @(posedge clk) begin
      if (load_req) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) ram[r*COLS+c] <= img[r][c];
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_we) wr_cnt <= wr_cnt + 1;
      if (bus.mem_we && bus.mem_rd_en) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_img();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) img[r][c] = '0;
   endtask

   task automatic fill_row(input int r, input logic [CW-1:0] v);
      for (int c = 0; c < COLS; c++) img[r][c] = v;
   endtask

   task automatic load_board();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic random_img();
      for (int r = 0; r < ROWS; r++) begin
         int k = $urandom_range(0, 3);
         for (int c = 0; c < COLS; c++) begin
            if (k == 0)      img[r][c] = CW'($urandom_range(1, 7));
            else if (k == 1) img[r][c] = '0;
            else             img[r][c] = CW'($urandom_range(0, 7));
         end
      end
   endtask

   // Reference: keep non-full rows in bottom-up order, stack them at the bottom, zero the rest.
   task automatic run_pass(input string name, input int restart_at);
      logic [CW-1:0] exp_b [ROWS][COLS];
      int lines, moved, d, n, wr0, bad, extra, exp_lat;
      logic full, done_seen;
      lines = 0; moved = 0; d = ROWS - 1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) exp_b[r][c] = '0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         full = 1'b1;
         for (int c = 0; c < COLS; c++) if (img[r][c] == '0) full = 1'b0;
         if (full) lines++;
         else begin
            for (int c = 0; c < COLS; c++) exp_b[d][c] = img[r][c];
            if (d != r) moved++;
            d--;
         end
      end
      exp_lat = ROWS*(COLS+1) + moved*COLS + lines*COLS + 2;

      load_board();
      wr0 = wr_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      n = 1;
      done_seen = 1'b0;
      while (!done_seen && n < 3000) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         n++;
         if (n == 2) check({name, "_busy_rise"}, bus.busy, 1);
         if (n == restart_at) bus.start = 1'b1;
         if (bus.done === 1'b1) done_seen = 1'b1;
      end
      check({name, "_done_seen"}, done_seen, 1);
      check({name, "_latency"}, n, exp_lat);
      check({name, "_lines"}, bus.lines_cleared, lines);
      @(posedge clk); #1;
      check({name, "_done_fall"}, bus.done, 0);
      check({name, "_busy_fall"}, bus.busy, 0);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      end
      check({name, "_quiet_after"}, extra, 0);
      check({name, "_lines_hold"}, bus.lines_cleared, lines);
      check({name, "_writes"}, wr_cnt - wr0, (moved + lines) * COLS);
      bad = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) if (ram[r*COLS+c] !== exp_b[r][c]) bad++;
      check({name, "_ram_cells"}, bad, 0);
   endtask

   initial begin
      int n;
      bus.start     = 1'b0;
      bus.mem_rdata = '0;
      load_req      = 1'b0;
      reset         = 1'b1;
      clear_img();
      #3 reset = 1'b0;
      #2;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_rd_en", bus.mem_rd_en, 0);
      check("rst_we", bus.mem_we, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_wdata", bus.mem_wdata, 0);
      check("rst_lines", bus.lines_cleared, 0);
      check("rst_state", dbg_state, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      clear_img();
      run_pass("empty", 0);

      clear_img();
      fill_row(19, 3'd2);
      img[18][0] = 3'd1;
      run_pass("one_line", 0);

      clear_img();
      for (int r = 16; r < 20; r++) fill_row(r, CW'(r % 7 + 1));
      run_pass("tetris", 0);

      for (int r = 0; r < ROWS; r++) fill_row(r, 3'd5);
      run_pass("full_board", 0);

      clear_img();
      fill_row(19, 3'd4);
      fill_row(10, 3'd6);
      img[18][3] = 3'd7;
      img[12][9] = 3'd1;
      run_pass("restart_ignored", 50);

      // Abort in the middle of a WRITE burst.
      clear_img();
      fill_row(19, 3'd3);
      img[18][0] = 3'd1;
      load_board();
      @(negedge clk);
      bus.start = 1'b1;
      n = 0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (bus.mem_we !== 1'b1 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_reached_write", bus.mem_we, 1);
      #2 reset = 1'b0;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_we", bus.mem_we, 0);
      check("abort_lines", bus.lines_cleared, 0);
      @(negedge clk);
      reset = 1'b1;
      clear_img();
      for (int r = 16; r < 20; r++) fill_row(r, 3'd7);
      img[15][5] = 3'd2;
      run_pass("after_abort", 0);

      for (int t = 0; t < 6; t++) begin
         random_img();
         run_pass($sformatf("rand%0d", t), 0);
      end

      check("strobe_exclusive", both_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
